// File: rtl/AHB_package.sv
// rtl/AHB_package.sv - AHB burst encoding plus arbiter beat helpers
package AHB_package;

  typedef enum logic [2:0] {
    SINGLE = 3'd0,
    INCR   = 3'd1,
    WRAP4  = 3'd2,
    INCR4  = 3'd3,
    WRAP8  = 3'd4,
    INCR8  = 3'd5,
    WRAP16 = 3'd6,
    INCR16 = 3'd7
  } hburst_type;

  localparam int ARB_BEAT_W = 4;

  // Index of the final beat; INCR has no fixed length and reports the counter ceiling.
  function automatic logic [ARB_BEAT_W-1:0] burst_limit(input hburst_type burst);
    case (burst)
      SINGLE:         burst_limit = 4'd0;
      WRAP4, INCR4:   burst_limit = 4'd3;
      WRAP8, INCR8:   burst_limit = 4'd7;
      WRAP16, INCR16: burst_limit = 4'd15;
      default:        burst_limit = 4'hF;
    endcase
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick starting after last_ptr
module rr_pick #(
  parameter int REQ_NUM = 4,
  parameter int IDX_W   = 2
) (
  input  logic [REQ_NUM-1:0] req,
  input  logic [IDX_W-1:0]   last_ptr,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);

  logic [REQ_NUM-1:0] rot;
  logic [IDX_W-1:0]   src;
  int                 off;

  // Rotate so bit 0 is the master just after last_ptr, take the lowest set bit, rotate back.
  always_comb begin
    rot = '0;
    src = '0;
    off = 0;
    for (int i = 0; i < REQ_NUM; i++) begin
      src    = IDX_W'((int'(last_ptr) + 1 + i) % REQ_NUM);
      rot[i] = req[src];
    end
    for (int i = REQ_NUM - 1; i >= 0; i--) begin
      if (rot[i]) off = i;
    end
    valid = |rot;
    idx   = IDX_W'((int'(last_ptr) + 1 + off) % REQ_NUM);
  end

endmodule

// File: rtl/ahb_slave_rr_arbiter.sv
// rtl/ahb_slave_rr_arbiter.sv - burst-aware round-robin arbiter for one AHB slave port
module ahb_slave_rr_arbiter
  import AHB_package::*;
#(
  parameter int MASTER_NUM = 4,
  parameter int IDX_W      = $clog2(MASTER_NUM)
) (
  input  logic                    hclk,
  input  logic                    hreset_n,
  input  logic [MASTER_NUM-1:0]   hreq,
  input  logic [MASTER_NUM*3-1:0] hburst,
  input  logic                    hready,
  output logic [MASTER_NUM-1:0]   hgrant,
  output logic                    hsel,
  output logic [IDX_W-1:0]        hmaster,
  output logic                    hlast
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BURST = 1'b1;

  logic [0:0]            state;
  hburst_type            burst;
  logic [ARB_BEAT_W-1:0] beat;
  logic [ARB_BEAT_W-1:0] limit;
  logic [IDX_W-1:0]      last_ptr;
  logic [IDX_W-1:0]      pick_idx;
  logic                  pick_valid;
  logic                  is_incr;
  logic                  release_now;
  logic                  take;

  rr_pick #(
    .REQ_NUM (MASTER_NUM),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req      (hreq),
    .last_ptr (last_ptr),
    .valid    (pick_valid),
    .idx      (pick_idx)
  );

  assign limit   = burst_limit(burst);
  assign is_incr = (burst == INCR);
  assign hsel    = |hgrant;

  // Undefined-length bursts end when the owner lets go of its request.
  always_comb begin
    hlast = 1'b0;
    if (state == BURST) begin
      hlast = is_incr ? ~hreq[hmaster] : (beat == limit);
    end
  end

  assign release_now = (state == BURST) && hlast && hready;
  assign take        = (state == IDLE) || release_now;

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state    <= IDLE;
      burst    <= SINGLE;
      beat     <= '0;
      last_ptr <= IDX_W'(MASTER_NUM - 1);
      hgrant   <= '0;
      hmaster  <= '0;
    end else if (take) begin
      beat <= '0;
      if (pick_valid) begin
        state    <= BURST;
        hgrant   <= {{(MASTER_NUM-1){1'b0}}, 1'b1} << pick_idx;
        hmaster  <= pick_idx;
        last_ptr <= pick_idx;
        burst    <= hburst_type'(hburst[pick_idx*3 +: 3]);
      end else begin
        state   <= IDLE;
        hgrant  <= '0;
        hmaster <= '0;
      end
    end else if ((state == BURST) && hready) begin
      if (!(is_incr && (beat == 4'hF))) begin
        beat <= beat + 1'b1;
      end
    end
  end

endmodule
